// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with frame, parity and overrun flags.
//            Optional parity bit after bit 7 when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ack,
   input  logic       err_clr,
   output logic [7:0] data_RX,
   output logic       valid_RX,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int c_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam int c_SMP_W = $clog2(OVERSAMPLE);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
   localparam logic [c_SMP_W-1:0] c_HALF_LAST = c_SMP_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_SMP_W-1:0] c_FULL_LAST = c_SMP_W'(OVERSAMPLE - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] c_AFTER_DATA = S_PARITY;
`else
   localparam logic [2:0] c_AFTER_DATA = S_STOP;
`endif

   logic [2:0]         r_state;
   logic [2:0]         w_next_state;
   logic               r_sync1;
   logic               r_sync2;
   logic               r_rx_prev;
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [c_SMP_W-1:0] r_smp_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic [7:0]         r_data;
   logic               r_valid;
   logic               r_frame_err;
   logic               r_overrun_err;
   logic               r_par_bad;
   logic               w_rx_s;
   logic               w_tick;
   logic               w_start;
   logic               w_sample;
   logic               w_deliver;
   logic               w_frame_set;
   logic               w_parity_set;
   logic               w_busy;

   assign w_rx_s = r_sync2;
   assign w_tick = (r_div_cnt == c_DIV_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_start)  w_next_state = S_START;
         S_START:  if (w_sample) w_next_state = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (w_sample && (r_bit_idx == 3'd7)) w_next_state = c_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (w_sample) w_next_state = S_STOP;
`endif
         S_STOP:   if (w_sample) w_next_state = w_rx_s ? S_IDLE : S_BREAK;
         S_BREAK:  if (w_rx_s)   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs; START samples mid-bit, later states one full bit apart
   always_comb begin
      w_busy       = (r_state != S_IDLE);
      w_start      = 1'b0;
      w_sample     = 1'b0;
      w_deliver    = 1'b0;
      w_frame_set  = 1'b0;
      w_parity_set = 1'b0;
      case (r_state)
         S_IDLE:  w_start  = r_rx_prev & ~w_rx_s;
         S_START: w_sample = w_tick & (r_smp_cnt == c_HALF_LAST);
         S_BREAK: w_sample = 1'b0;
         default: w_sample = w_tick & (r_smp_cnt == c_FULL_LAST);
      endcase
      if (r_state == S_STOP && w_sample) begin
         w_frame_set  = ~w_rx_s;
         w_parity_set = w_rx_s & r_par_bad;
         w_deliver    = w_rx_s & ~r_par_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_rx_prev     <= 1'b1;
         r_div_cnt     <= '0;
         r_smp_cnt     <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_sync1   <= rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;

         // Restarting the divider on the start edge aligns ticks to the bit
         if (w_start || w_tick) r_div_cnt <= '0;
         else                   r_div_cnt <= r_div_cnt + 1'b1;

         if (w_start)     r_smp_cnt <= '0;
         else if (w_tick) r_smp_cnt <= w_sample ? '0 : r_smp_cnt + 1'b1;

         if (r_state == S_START)              r_bit_idx <= '0;
         else if (r_state == S_DATA && w_sample) r_bit_idx <= r_bit_idx + 1'b1;

         if (r_state == S_DATA && w_sample) r_shift <= {w_rx_s, r_shift[7:1]};

         if (w_deliver) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (rx_ack) begin
            r_valid <= 1'b0;
         end

         if (w_deliver && r_valid && !rx_ack) r_overrun_err <= 1'b1;
         else if (err_clr)                    r_overrun_err <= 1'b0;

         if (w_frame_set)  r_frame_err <= 1'b1;
         else if (err_clr) r_frame_err <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parity_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (r_state == S_START) r_par_bad <= 1'b0;
         else if (r_state == S_PARITY && w_sample)
            r_par_bad <= ((^r_shift) ^ w_rx_s) != (PARITY_ODD != 0);

         if (w_parity_set) r_parity_err <= 1'b1;
         else if (err_clr) r_parity_err <= 1'b0;
      end
   end

   assign parity_err = r_parity_err;
`else
   assign r_par_bad  = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign data_RX     = r_data;
   assign valid_RX    = r_valid;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
   assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (DIV=10, 160 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int c_BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
   localparam int c_RX_BUDGET = 1780;
`else
   localparam int c_RX_BUDGET = 1620;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ack;
   logic       err_clr;
   logic [7:0] data_RX;
   logic       valid_RX;
   logic       frame_err;
   logic       parity_err;
   logic       overrun_err;
   logic       busy;
   logic       abort_tx;
   logic       ok;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ  (1600000),
      .BAUD      (10000),
      .OVERSAMPLE(16),
      .PARITY_ODD(0)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_ack     (rx_ack),
      .err_clr    (err_clr),
      .data_RX    (data_RX),
      .valid_RX   (valid_RX),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      logic [10:0] bits;
      int          n;
`ifdef UART_RX_PARITY_EN
      bits = {stop, par, b, 1'b0};
      n    = 11;
`else
      bits = {par | 1'b1, stop, b, 1'b0};
      n    = 10;
`endif
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < c_BIT_CLK; k++) begin
            @(negedge clk);
            rx = abort_tx ? 1'b1 : bits[i];
         end
      end
   endtask

   task automatic wait_valid(input int budget, output logic found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid_RX) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic recv(input logic [7:0] b, input logic par, input string tag);
      logic f;
      f = 1'b0;
      fork
         send_frame(b, par, 1'b1);
         wait_valid(c_RX_BUDGET, f);
      join
      check({tag, "_valid"}, {31'd0, f}, 32'd1);
      check({tag, "_data"}, {24'd0, data_RX}, {24'd0, b});
   endtask

   initial begin
      rst      = 1'b0;
      rx       = 1'b1;
      rx_ack   = 1'b0;
      err_clr  = 1'b0;
      abort_tx = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {18'd0, data_RX, valid_RX, frame_err, parity_err, overrun_err, busy, 1'b0}, 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 0xA5: valid within budget, ack 5 clk later, valid drops the next cycle
      fork
         send_frame(8'hA5, 1'b0, 1'b1);
         begin
            wait_valid(c_RX_BUDGET, ok);
            check("a5_latency", {31'd0, ok}, 32'd1);
            check("a5_data", {24'd0, data_RX}, 32'h0000_00A5);
            repeat (4) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            check("a5_valid_after_ack", {31'd0, valid_RX}, 32'd0);
         end
      join
      check("a5_flags", {29'd0, frame_err, parity_err, overrun_err}, 32'd0);

      // Glitch shorter than half a bit
      @(negedge clk);
      rx = 1'b0;
      repeat (30) @(negedge clk);
      check("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (30) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_quiet", {28'd0, valid_RX, frame_err, overrun_err, busy}, 32'd0);

      // 0x3C with low stop bit, line held low, then 0x41
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (500) @(negedge clk);
      check("break_frame_err", {31'd0, frame_err}, 32'd1);
      check("break_no_valid", {31'd0, valid_RX}, 32'd0);
      check("break_busy_held", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("break_released", {30'd0, busy, valid_RX}, 32'd0);
      recv(8'h41, 1'b0, "after_break");
      do_ack();
      check("frame_err_sticky", {31'd0, frame_err}, 32'd1);
      pulse_clr();
      check("frame_err_cleared", {31'd0, frame_err}, 32'd0);

      // Back-to-back 0x11, 0x22 without ack
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      check("overrun_set", {31'd0, overrun_err}, 32'd1);
      check("overrun_data", {24'd0, data_RX}, 32'h0000_0022);
      check("overrun_valid", {31'd0, valid_RX}, 32'd1);
      pulse_clr();
      check("overrun_cleared", {30'd0, overrun_err, valid_RX}, 32'd1);
      do_ack();
      check("overrun_acked", {31'd0, valid_RX}, 32'd0);

`ifdef UART_RX_PARITY_EN
      recv(8'h07, 1'b1, "parity_good");
      check("parity_good_flag", {31'd0, parity_err}, 32'd0);
      do_ack();
      send_frame(8'h07, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      check("parity_bad_flag", {31'd0, parity_err}, 32'd1);
      check("parity_bad_discard", {31'd0, valid_RX}, 32'd0);
      pulse_clr();
      check("parity_cleared", {31'd0, parity_err}, 32'd0);
`endif

      // Reset pulse during data bit 3 of 0x5A
      fork
         send_frame(8'h5A, 1'b0, 1'b1);
         begin
            repeat (700) @(negedge clk);
            check("mid_frame_busy", {31'd0, busy}, 32'd1);
            rst      = 1'b0;
            abort_tx = 1'b1;
            @(negedge clk);
            check("mid_frame_reset", {18'd0, data_RX, valid_RX, frame_err, parity_err, overrun_err, busy, 1'b0}, 32'd0);
            rst = 1'b1;
         end
      join
      abort_tx = 1'b0;
      repeat (50) @(negedge clk);
      check("post_reset_quiet", {28'd0, valid_RX, frame_err, overrun_err, busy}, 32'd0);
      recv(8'h5A, 1'b0, "post_reset");
      do_ack();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
